// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 system-control register file.
//   Holds BadVAddr, Count, Compare, Status, Cause, EPC, ErrEPC, EntryHi,
//   Context, Ebase and PRId. Serves MTC0 writes / MFC0 reads, takes exception
//   and ERET commits, runs the Count/Compare timer and flags pending interrupts.
// Optional feature: define CP0_TIMER_INT_EN to enable the timer interrupt
//   (Cause.TI, OR-ed into IP7). Without it TI is constant 0.
// Ports:
//   clk, Reset (synchronous, active-high)
//   mtc0_we/addr/sel/wdata      register write (visible next cycle)
//   mfc0_addr/sel -> mfc0_rdata combinational read, unmapped -> 0
//   hw_int[5:0]                 external interrupt lines -> Cause.IP[7:2]
//   exc_valid/code/epc/bd       exception commit
//   badvaddr_*/context_*/entryhi_*  fault-address updates, only with exc_valid
//   eret                        ERET commit
//   Status/Cause/EPC/ErrEPC/Ebase   live register values
//   eret_target                 ERL ? ErrEPC : EPC
//   int_pending                 unmasked interrupt pending and enabled
module cp0_regfile #(
  parameter logic [31:0] PRID           = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET    = 32'h8000_0000,
  parameter int unsigned COUNT_DIV_LOG2 = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_rdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_in,
  input  logic        context_we,
  input  logic [18:0] context_vpn2,
  input  logic        entryhi_we,
  input  logic [18:0] entryhi_vpn2,
  input  logic        eret,
  output logic [31:0] Status,
  output logic [31:0] Cause,
  output logic [31:0] EPC,
  output logic [31:0] ErrEPC,
  output logic [31:0] Ebase,
  output logic [31:0] eret_target,
  output logic        int_pending
);

  localparam int unsigned DIV_W = (COUNT_DIV_LOG2 == 0) ? 1 : COUNT_DIV_LOG2;

  localparam logic [4:0] REG_CONTEXT  = 5'd4;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_ERREPC   = 5'd30;

  localparam logic [31:0] STATUS_RESET   = 32'h0040_0004;
  localparam logic [31:0] STATUS_WMASK   = 32'h0040_FF07;
  localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] CONTEXT_WMASK  = 32'hFF80_0000;
  localparam logic [31:0] EBASE_WMASK    = 32'h3FFF_F000;

  logic [31:0]      badvaddr_q, count_q, compare_q, entryhi_q, ctx_q;
  logic             cause_bd, cause_iv, cause_ti;
  logic [1:0]       cause_ip_sw;
  logic [5:0]       cause_ip_hw;
  logic [4:0]       cause_exc;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [31:0]      count_next, compare_next;

  // A flushed instruction's MTC0 never lands; ERET also outranks MTC0.
  logic mtc0_fire;
  logic wr_context, wr_badvaddr, wr_count, wr_entryhi, wr_compare;
  logic wr_status, wr_cause, wr_epc, wr_ebase, wr_errepc;

  assign mtc0_fire   = mtc0_we & ~exc_valid & ~eret;
  assign wr_context  = mtc0_fire && mtc0_addr == REG_CONTEXT  && mtc0_sel == 3'd0;
  assign wr_badvaddr = mtc0_fire && mtc0_addr == REG_BADVADDR && mtc0_sel == 3'd0;
  assign wr_count    = mtc0_fire && mtc0_addr == REG_COUNT    && mtc0_sel == 3'd0;
  assign wr_entryhi  = mtc0_fire && mtc0_addr == REG_ENTRYHI  && mtc0_sel == 3'd0;
  assign wr_compare  = mtc0_fire && mtc0_addr == REG_COMPARE  && mtc0_sel == 3'd0;
  assign wr_status   = mtc0_fire && mtc0_addr == REG_STATUS   && mtc0_sel == 3'd0;
  assign wr_cause    = mtc0_fire && mtc0_addr == REG_CAUSE    && mtc0_sel == 3'd0;
  assign wr_epc      = mtc0_fire && mtc0_addr == REG_EPC      && mtc0_sel == 3'd0;
  assign wr_ebase    = mtc0_fire && mtc0_addr == REG_PRID     && mtc0_sel == 3'd1;
  assign wr_errepc   = mtc0_fire && mtc0_addr == REG_ERREPC   && mtc0_sel == 3'd0;

  // Count prescaler: one Count increment each time the divider wraps.
  assign tick = (COUNT_DIV_LOG2 == 0) ? 1'b1 : (div_q == {DIV_W{1'b1}});

  // Post-update timer values; an MTC0 write beats the increment.
  always_comb begin
    count_next   = count_q;
    compare_next = compare_q;
    if (wr_count)  count_next = mtc0_wdata;
    else if (tick) count_next = count_q + 32'd1;
    if (wr_compare) compare_next = mtc0_wdata;
  end

  // Timer, divider and interrupt sampling.
  always_ff @(posedge clk) begin
    if (Reset) begin
      div_q       <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      cause_ip_hw <= '0;
    end else begin
      div_q       <= div_q + DIV_W'(1);
      count_q     <= count_next;
      compare_q   <= compare_next;
      cause_ip_hw <= hw_int;
    end
  end

`ifdef CP0_TIMER_INT_EN
  // Sticky timer flag; a Compare write clears it even on a match.
  logic ti_q;
  always_ff @(posedge clk) begin
    if (Reset)                          ti_q <= 1'b0;
    else if (wr_compare)                ti_q <= 1'b0;
    else if (count_next == compare_next) ti_q <= 1'b1;
  end
  assign cause_ti = ti_q;
`else
  assign cause_ti = 1'b0;
`endif

  // Status: exception sets EXL, ERET clears ERL first then EXL.
  always_ff @(posedge clk) begin
    if (Reset)          Status <= STATUS_RESET;
    else if (exc_valid) Status[1] <= 1'b1;
    else if (eret) begin
      if (Status[2]) Status[2] <= 1'b0;
      else           Status[1] <= 1'b0;
    end else if (wr_status)
      Status <= (Status & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
  end

  // Cause/EPC: victim PC and BD captured only on the first nested exception.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cause_bd    <= 1'b0;
      cause_iv    <= 1'b0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      EPC         <= '0;
    end else if (exc_valid) begin
      cause_exc <= exc_code;
      if (!Status[1]) begin
        EPC      <= exc_epc;
        cause_bd <= exc_bd;
      end
    end else begin
      if (wr_cause) begin
        cause_iv    <= mtc0_wdata[23];
        cause_ip_sw <= mtc0_wdata[9:8];
      end
      if (wr_epc) EPC <= mtc0_wdata;
    end
  end

  // Fault-address registers, ErrEPC and Ebase.
  always_ff @(posedge clk) begin
    if (Reset) begin
      badvaddr_q <= '0;
      ctx_q      <= '0;
      entryhi_q  <= '0;
      ErrEPC     <= '0;
      Ebase      <= EBASE_RESET;
    end else if (exc_valid) begin
      if (badvaddr_we) badvaddr_q      <= badvaddr_in;
      if (context_we)  ctx_q[22:4]     <= context_vpn2;
      if (entryhi_we)  entryhi_q[31:13] <= entryhi_vpn2;
    end else begin
      if (wr_badvaddr) badvaddr_q <= mtc0_wdata;
      if (wr_context)  ctx_q      <= (ctx_q & ~CONTEXT_WMASK) | (mtc0_wdata & CONTEXT_WMASK);
      if (wr_entryhi)  entryhi_q  <= (entryhi_q & ~ENTRYHI_WMASK) | (mtc0_wdata & ENTRYHI_WMASK);
      if (wr_errepc)   ErrEPC     <= mtc0_wdata;
      if (wr_ebase)    Ebase      <= (Ebase & ~EBASE_WMASK) | (mtc0_wdata & EBASE_WMASK);
    end
  end

  assign Cause = {cause_bd, cause_ti, 6'b0, cause_iv, 7'b0,
                  cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw,
                  1'b0, cause_exc, 2'b0};

  assign eret_target = Status[2] ? ErrEPC : EPC;
  assign int_pending = Status[0] & ~Status[1] & ~Status[2] & (|(Cause[15:8] & Status[15:8]));

  // MFC0 read mux.
  always_comb begin
    mfc0_rdata = 32'h0;
    case ({mfc0_addr, mfc0_sel})
      {REG_CONTEXT,  3'd0}: mfc0_rdata = ctx_q;
      {REG_BADVADDR, 3'd0}: mfc0_rdata = badvaddr_q;
      {REG_COUNT,    3'd0}: mfc0_rdata = count_q;
      {REG_ENTRYHI,  3'd0}: mfc0_rdata = entryhi_q;
      {REG_COMPARE,  3'd0}: mfc0_rdata = compare_q;
      {REG_STATUS,   3'd0}: mfc0_rdata = Status;
      {REG_CAUSE,    3'd0}: mfc0_rdata = Cause;
      {REG_EPC,      3'd0}: mfc0_rdata = EPC;
      {REG_PRID,     3'd0}: mfc0_rdata = PRID;
      {REG_PRID,     3'd1}: mfc0_rdata = Ebase;
      {REG_ERREPC,   3'd0}: mfc0_rdata = ErrEPC;
      default:              mfc0_rdata = 32'h0;
    endcase
  end

endmodule
